// File: rtl/alu_issue_if.sv
// Purpose : operand/opcode handshake bundle between the register-read stage,
//           alu_issue and the combinational ALU.
// Signals : in_valid/in_ready + decoded instruction fields (upstream side),
//           out_valid/out_ready + SrcA/SrcB/Operation/Pc4/illegal (ALU side).
// Modports: master - environment view (drives instruction, consumes results)
//           slave  - alu_issue view
interface alu_issue_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4,
    parameter int unsigned PC_WIDTH      = 9
);
    logic                     in_valid;
    logic                     in_ready;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic [PC_WIDTH-1:0]      pc;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [PC_WIDTH-1:0]      Pc4;
    logic                     illegal;

    modport master (
        output in_valid, opcode, funct3, funct7, rs1_data, rs2_data, imm, pc, out_ready,
        input  in_ready, out_valid, SrcA, SrcB, Operation, Pc4, illegal
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7, rs1_data, rs2_data, imm, pc, out_ready,
        output in_ready, out_valid, SrcA, SrcB, Operation, Pc4, illegal
    );
endinterface

// File: rtl/alu_issue.sv
// Purpose : decodes RV32I fields into the ALU Operation code and operands, then
//           registers them through a 2-entry skid buffer (valid/ready both sides).
//           in_ready is a flop, so a downstream stall never reaches upstream
//           combinationally.
// Ports   : clk, reset_n (async active-low), bus (alu_issue_if.slave).
// Option  : ALU_ISSUE_PERF_EN adds issue_count[31:0] (takes) and
//           stall_count[31:0] (cycles with out_valid && !out_ready).
module alu_issue #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4,
    parameter int unsigned PC_WIDTH      = 9
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0] issue_count,
    output logic [31:0] stall_count,
`endif
    alu_issue_if.slave  bus
);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_BGE = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_BNE = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_LUI = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_BLT = OPCODE_LENGTH'(4'b1101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b1110);
    localparam logic [OPCODE_LENGTH-1:0] OP_BAD = OPCODE_LENGTH'(4'b1111);

    // Offset the ALU strips from SrcB to recognise an arithmetic shift amount
    localparam logic [DATA_WIDTH-1:0] SRA_OFFSET = DATA_WIDTH'(1024);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    src_a;
        logic [DATA_WIDTH-1:0]    src_b;
        logic [OPCODE_LENGTH-1:0] op;
        logic [PC_WIDTH-1:0]      pc4;
        logic                     illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_in_ready;
    logic                     r_out_valid;
    entry_t                   r_main;
    entry_t                   r_skid;
    entry_t                   w_entry;
    logic [OPCODE_LENGTH-1:0] w_op;
    logic [DATA_WIDTH-1:0]    w_src_b;
    logic                     w_illegal;
    logic                     w_accept;
    logic                     w_take;
    logic                     w_load_main;
    logic                     w_load_skid;
    logic                     w_skid_to_main;

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_take   = r_out_valid && bus.out_ready;

    // Instruction decode; anything unmatched falls through as illegal with SrcB=rs2
    always_comb begin
        w_op      = OP_BAD;
        w_src_b   = bus.rs2_data;
        w_illegal = 1'b1;
        case (bus.opcode)
            OPC_R: begin
                case (bus.funct3)
                    3'b000: begin
                        if (bus.funct7 == F7_ZERO) begin
                            w_op      = OP_ADD;
                            w_illegal = 1'b0;
                        end else if (bus.funct7 == F7_ALT) begin
                            w_op      = OP_SUB;
                            w_illegal = 1'b0;
                        end
                    end
                    3'b111: begin w_op = OP_AND; w_illegal = 1'b0; end
                    3'b110: begin w_op = OP_OR;  w_illegal = 1'b0; end
                    3'b100: begin w_op = OP_XOR; w_illegal = 1'b0; end
                    3'b010: begin w_op = OP_SLT; w_illegal = 1'b0; end
                    default: ;
                endcase
            end
            OPC_I: begin
                case (bus.funct3)
                    3'b000: begin w_op = OP_ADD; w_src_b = bus.imm; w_illegal = 1'b0; end
                    3'b010: begin w_op = OP_SLT; w_src_b = bus.imm; w_illegal = 1'b0; end
                    3'b001: begin w_op = OP_SLL; w_src_b = bus.imm; w_illegal = 1'b0; end
                    3'b101: begin
                        if (bus.funct7 == F7_ZERO) begin
                            w_op      = OP_SRL;
                            w_src_b   = bus.imm;
                            w_illegal = 1'b0;
                        end else if (bus.funct7 == F7_ALT) begin
                            w_op      = OP_SRA;
                            w_src_b   = SRA_OFFSET + DATA_WIDTH'(bus.imm[4:0]);
                            w_illegal = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            OPC_LUI: begin
                w_op      = OP_LUI;
                w_src_b   = bus.imm;
                w_illegal = 1'b0;
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                w_op      = OP_ADD;
                w_src_b   = bus.imm;
                w_illegal = 1'b0;
            end
            OPC_BRANCH: begin
                case (bus.funct3)
                    3'b000: begin w_op = OP_EQ;  w_illegal = 1'b0; end
                    3'b001: begin w_op = OP_BNE; w_illegal = 1'b0; end
                    3'b100: begin w_op = OP_BLT; w_illegal = 1'b0; end
                    3'b101: begin w_op = OP_BGE; w_illegal = 1'b0; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        w_entry.src_a   = bus.rs1_data;
        w_entry.src_b   = w_src_b;
        w_entry.op      = w_op;
        w_entry.pc4     = bus.pc + PC_WIDTH'(4);
        w_entry.illegal = w_illegal;
    end

    // Skid-buffer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) w_state_nxt = ST_ONE;
            end
            ST_ONE: begin
                if (w_accept && !w_take)      w_state_nxt = ST_FULL;
                else if (!w_accept && w_take) w_state_nxt = ST_EMPTY;
            end
            ST_FULL: begin
                if (w_take) w_state_nxt = ST_ONE;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Datapath steering per state
    always_comb begin
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            ST_EMPTY: w_load_main = w_accept;
            ST_ONE: begin
                w_load_main = w_accept && w_take;
                w_load_skid = w_accept && !w_take;
            end
            ST_FULL:  w_skid_to_main = w_take;
            default: ;
        endcase
    end

    // Handshake flags are flopped from the next state, never from out_ready directly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
        end
    end

    // Main/skid payload registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= w_entry;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_entry;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.SrcA      = r_main.src_a;
    assign bus.SrcB      = r_main.src_b;
    assign bus.Operation = r_main.op;
    assign bus.Pc4       = r_main.pc4;
    assign bus.illegal   = r_main.illegal;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] r_issue_count;
    logic [31:0] r_stall_count;

    // Free-running event counters, wrap at 2^32
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_issue_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_take) r_issue_count <= r_issue_count + 32'd1;
            if (r_out_valid && !bus.out_ready) r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign issue_count = r_issue_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Producer end of the ALU operand/opcode interface: decodes RV32I instruction fields into the 4-bit ALU Operation code and selects SrcA/SrcB/Pc4.
- Registers the results through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Sits between the register-read stage and the combinational ALU, so a downstream stall never combinationally reaches upstream ready.

Parameters:
- DATA_WIDTH, 32, operand width.
- OPCODE_LENGTH, 4, ALU Operation code width.
- PC_WIDTH, 9, program counter width (matches the ALU Pc4 port).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream holds a decoded instruction
- in_ready  output  1  block accepts the instruction this cycle
- opcode  input  7  instr[6:0]
- funct3  input  3  instr[14:12]
- funct7  input  7  instr[31:25]
- rs1_data  input  DATA_WIDTH  register-file read port 1
- rs2_data  input  DATA_WIDTH  register-file read port 2
- imm  input  DATA_WIDTH  sign-extended immediate from the immediate generator
- pc  input  PC_WIDTH  instruction address
- out_valid  output  1  SrcA/SrcB/Operation/Pc4 are valid
- out_ready  input  1  ALU stage consumes this cycle
- SrcA  output  DATA_WIDTH  ALU operand A
- SrcB  output  DATA_WIDTH  ALU operand B
- Operation  output  OPCODE_LENGTH  ALU operation code
- Pc4  output  PC_WIDTH  pc+4, modulo 2^PC_WIDTH
- illegal  output  1  decoded instruction is unsupported

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, in_ready=1, SrcA=0, SrcB=0, Operation=4'b0000, Pc4=0, illegal=0. Both buffer entries are emptied.
- Decode is combinational, at the input. SrcA is always rs1_data.
- R-type (0110011), SrcB=rs2_data, by funct3/funct7:
  - 000/0000000 ADD 0100; 000/0100000 SUB 0010.
  - 111 AND 0000; 110 OR 0011; 100 XOR 0001; 010 SLT 1110.
- I-type ALU (0010011), SrcB=imm:
  - 000 ADDI 0100; 010 SLTI 1110; 001 SLLI 1001.
  - 101/0000000 SRLI 1100.
  - 101/0100000 SRAI 0111, SrcB=1024+shamt (the ALU removes the 1024 offset).
- LUI (0110111): 1010, SrcB=imm.
- Load (0000011), store (0100011), JALR (1100111): ADD 0100, SrcB=imm.
- Branch (1100011), SrcB=rs2_data:
  - 000 EQ 1000; 001 BNE 0110; 100 BLT 1101; 101 BGE 0101.
- Any other opcode/funct combination: Operation=4'b1111, SrcB=rs2_data, illegal=1. The entry is still issued.
- Pc4 = pc + 4, truncated to PC_WIDTH; 9'h1FC wraps to 9'h000.
- Skid buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main register valid, in_ready=1.
  - FULL: main and skid registers valid, in_ready=0.
- Transitions (accept = in_valid&&in_ready; take = out_valid&&out_ready):
  - EMPTY + accept -> ONE.
  - ONE + accept + !take -> FULL; the new entry goes to the skid register.
  - ONE + accept + take -> ONE; the main register is loaded with the new entry.
  - ONE + !accept + take -> EMPTY.
  - FULL + take -> ONE; skid moves to main.
- Latency is 1 cycle from accept to out_valid. Throughput is 1 per cycle while out_ready=1.
- in_ready is a registered output only; no combinational path from out_ready to in_ready.
- Outputs are stable while out_valid=1 and out_ready=0.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- Reset asserted mid-transfer discards both entries immediately; out_valid falls asynchronously.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- Defined: adds outputs issue_count[31:0] and stall_count[31:0].
  - issue_count increments on every take.
  - stall_count increments each cycle with out_valid=1 and out_ready=0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- ADD stream: opcode=0110011, funct3=000, funct7=0, rs1=5, rs2=7, out_ready=1, one instruction per cycle -> Operation=0100, SrcA=5, SrcB=7 one cycle later; throughput 1/cycle; in_ready stays 1.
- SRAI: opcode=0010011, funct3=101, funct7=0100000, shamt=3, rs1=32'hFFFFFF00 -> Operation=0111, SrcB=1027 (ALU then yields 32'hFFFFFFE0).
- Backpressure: out_ready=0, 3 valid inputs A,B,C -> A held on outputs, B in skid, in_ready=0 before C is accepted; out_ready=1 -> A, B, C emitted in order, nothing lost.
- Branch and illegal mix: BNE (001), BGE (101), then opcode 1110011 -> Operation 0110, then 0101, then 1111 with illegal=1.
- Pc4 wrap: pc=9'h1FC -> Pc4=9'h000; pc=9'h010 -> Pc4=9'h014.
- Reset mid-stall: FULL state, reset_n pulled low between clock edges -> out_valid=0 and in_ready=1 immediately; after release, the first output is the next accepted instruction.
